// File: rtl/spi_tx_master.sv
// spi_tx_master: SPI mode-0 transmit master with a byte FIFO.
// Bytes pushed on the store path are queued, then shifted out MSB-first
// on spi_mosi with a programmable SCLK rate. spi_miso is captured into
// rx_data for every frame. Back-to-back bytes share one slave-select window.
//
// Ports:
//   spi_clk, rst          block clock (rising edge), async active-high reset
//   wr_en, wr_data        push one byte into the TX FIFO
//   fifo_full, fifo_count FIFO occupancy
//   overflow              sticky, set by a write while the FIFO is full
//   busy                  serializer not idle
//   spi_miso              serial data from slave
//   rx_data, rx_valid     last received byte and its one-cycle update strobe
//   spi_clk_o, spi_ss, spi_mosi  SPI pins (SCLK idles low, SS active low)
module spi_tx_master #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                          spi_clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy,
  input  logic                          spi_miso,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic                          spi_clk_o,
  output logic                          spi_ss,
  output logic                          spi_mosi
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             sclk_q, sclk_d;
  logic             ss_q, ss_d;
  logic             mosi_q, mosi_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             half_end;
  logic [7:0]       head;

  assign push       = wr_en && !full_q;
  assign fifo_empty = (count_q == CNT_W'(0));
  assign half_end   = (div_q == DIV_W'(CLK_DIV - 1));
  assign head       = mem_q[rd_ptr_q];

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge spi_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(FIFO_DEPTH));
    // a write while full is dropped even if a pop frees a slot this cycle
    ovf_d  = ovf_q || (wr_en && full_q);
  end

  // Serializer next state and outputs
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    ss_d       = ss_q;
    mosi_d     = mosi_q;
    pop        = 1'b0;
    // half-period timer free-runs outside IDLE and restarts on every boundary
    if (state_q == ST_IDLE) begin
      div_d = DIV_W'(0);
    end else if (half_end) begin
      div_d = DIV_W'(0);
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        ss_d   = 1'b1;
        sclk_d = 1'b0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          tx_sh_d = head;
          mosi_d  = head[7];
          ss_d    = 1'b0;
          bit_d   = 3'd0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (half_end) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], spi_miso};
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (half_end) begin
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            state_d    = ST_TAIL;
          end else begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            mosi_d  = tx_sh_q[6];
            bit_d   = bit_q + 3'd1;
            state_d = ST_LOW;
          end
        end
      end
      ST_TAIL: begin
        if (half_end) begin
          // chain the next byte inside the same SS window when one is queued
          if (!fifo_empty) begin
            pop     = 1'b1;
            tx_sh_d = head;
            mosi_d  = head[7];
            bit_d   = 3'd0;
            state_d = ST_LOW;
          end else begin
            ss_d    = 1'b1;
            mosi_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State registers
  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= 3'd0;
      tx_sh_q    <= 8'd0;
      rx_sh_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
    end
  end

  assign fifo_full  = full_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign spi_clk_o  = sclk_q;
  assign spi_ss     = ss_q;
  assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_spi_tx_master.sv
// tb_spi_tx_master: directed bench for spi_tx_master.
// Three instances (CLK_DIV = 2, 4, 1) share clock, reset and MISO; a pin
// monitor decodes the selected instance's SPI pins into bytes and timing.
module tb_spi_tx_master;

  logic       clk;
  logic       rst;
  logic       miso;
  logic       wr_en   [3];
  logic [7:0] wr_data [3];
  logic       full    [3];
  logic [4:0] cnt     [3];
  logic       ovf     [3];
  logic       busy    [3];
  logic [7:0] rxd     [3];
  logic       rxv     [3];
  logic       sclk    [3];
  logic       ss      [3];
  logic       mosi    [3];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_tx_master #(.FIFO_DEPTH(16), .CLK_DIV(2)) u_a (
    .spi_clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
    .fifo_full(full[0]), .fifo_count(cnt[0]), .overflow(ovf[0]), .busy(busy[0]),
    .spi_miso(miso), .rx_data(rxd[0]), .rx_valid(rxv[0]),
    .spi_clk_o(sclk[0]), .spi_ss(ss[0]), .spi_mosi(mosi[0]));

  spi_tx_master #(.FIFO_DEPTH(16), .CLK_DIV(4)) u_b (
    .spi_clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
    .fifo_full(full[1]), .fifo_count(cnt[1]), .overflow(ovf[1]), .busy(busy[1]),
    .spi_miso(miso), .rx_data(rxd[1]), .rx_valid(rxv[1]),
    .spi_clk_o(sclk[1]), .spi_ss(ss[1]), .spi_mosi(mosi[1]));

  spi_tx_master #(.FIFO_DEPTH(16), .CLK_DIV(1)) u_c (
    .spi_clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
    .fifo_full(full[2]), .fifo_count(cnt[2]), .overflow(ovf[2]), .busy(busy[2]),
    .spi_miso(miso), .rx_data(rxd[2]), .rx_valid(rxv[2]),
    .spi_clk_o(sclk[2]), .spi_ss(ss[2]), .spi_mosi(mosi[2]));

  // Pin monitor state (written only by the monitor process)
  int         sel;
  logic       mon_clr;
  logic       prev_sclk, prev_ss, rise_e, fall_e;
  int         rises, falls, ss_falls, ss_run, last_ss_low;
  int         low_run, gap_max, tail_len;
  int         nbits, nbytes, rxv_cnt, rxv_on_fall;
  logic [7:0] bitsh, last_rx;
  logic [7:0] bytes_q [32];

  always @(negedge clk) begin
    if (mon_clr) begin
      prev_sclk = sclk[sel]; prev_ss = ss[sel];
      rises = 0; falls = 0; ss_falls = 0; ss_run = 0; last_ss_low = 0;
      low_run = 0; gap_max = 0; tail_len = 0;
      nbits = 0; nbytes = 0; rxv_cnt = 0; rxv_on_fall = 0;
      bitsh = 8'd0; last_rx = 8'd0;
    end else begin
      rise_e = !prev_sclk && sclk[sel];
      fall_e = prev_sclk && !sclk[sel];
      if (prev_ss && !ss[sel]) begin
        ss_falls++; ss_run = 1; low_run = 1;
      end else if (!prev_ss && ss[sel]) begin
        last_ss_low = ss_run; tail_len = low_run;
      end else if (!ss[sel]) begin
        ss_run++;
        if (rise_e) begin
          if (low_run > gap_max) gap_max = low_run;
          low_run = 0;
        end else if (fall_e) begin
          low_run = 1;
        end else if (!sclk[sel]) begin
          low_run++;
        end
      end
      if (rise_e) begin
        rises++;
        bitsh = {bitsh[6:0], mosi[sel]};
        nbits++;
        if (nbits == 8) begin
          if (nbytes < 32) bytes_q[nbytes] = bitsh;
          nbytes++; nbits = 0;
        end
      end
      if (fall_e) falls++;
      if (rxv[sel]) begin
        rxv_cnt++; last_rx = rxd[sel];
        if (fall_e) rxv_on_fall++;
      end
      prev_sclk = sclk[sel]; prev_ss = ss[sel];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic push(input int s, input logic [7:0] d);
    wr_en[s] = 1'b1; wr_data[s] = d;
    step();
    wr_en[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s, input int bound, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!busy[s] && cnt[s] == 5'd0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) begin
      total++; bad++;
      $error("FAIL %s_timeout: observed=busy expected=idle within %0d cycles", tag, bound);
    end
    repeat (3) step();
  endtask

  logic [7:0] pat;
  bit         hit;

  initial begin
    rst = 1'b1; miso = 1'b0; sel = 0; mon_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin wr_en[i] = 1'b0; wr_data[i] = 8'd0; end
    repeat (3) step();

    // Reset values
    chk("rst_ss", ss[0], 1); chk("rst_sclk", sclk[0], 0); chk("rst_mosi", mosi[0], 0);
    chk("rst_rxd", rxd[0], 0); chk("rst_rxv", rxv[0], 0); chk("rst_ovf", ovf[0], 0);
    chk("rst_busy", busy[0], 0); chk("rst_cnt", cnt[0], 0); chk("rst_full", full[0], 0);
    rst = 1'b0;
    step();
    mon_clear();

    // Single byte 0x41 at CLK_DIV=2
    sel = 0; mon_clear();
    push(0, 8'h41);
    chk("t1_cnt", cnt[0], 1); chk("t1_ss_pre", ss[0], 1);
    step();
    chk("t1_ss_low", ss[0], 0); chk("t1_busy", busy[0], 1); chk("t1_mosi_b7", mosi[0], 0);
    wait_idle(0, 200, "t1");
    chk("t1_ss_len", last_ss_low, 34); chk("t1_nbytes", nbytes, 1);
    chk("t1_byte", bytes_q[0], 8'h41); chk("t1_rises", rises, 8); chk("t1_falls", falls, 8);
    chk("t1_gap", gap_max, 2); chk("t1_tail", tail_len, 2);
    chk("t1_ss_end", ss[0], 1); chk("t1_busy_end", busy[0], 0); chk("t1_rxv", rxv_cnt, 1);

    // Three back-to-back bytes in one SS window
    mon_clear();
    wr_en[0] = 1'b1; wr_data[0] = 8'h48; step();
    wr_data[0] = 8'h69; step();
    wr_data[0] = 8'h00; step();
    wr_en[0] = 1'b0;
    wait_idle(0, 500, "t2");
    chk("t2_ss_falls", ss_falls, 1); chk("t2_nbytes", nbytes, 3);
    chk("t2_b0", bytes_q[0], 8'h48); chk("t2_b1", bytes_q[1], 8'h69); chk("t2_b2", bytes_q[2], 8'h00);
    chk("t2_rises", rises, 24); chk("t2_falls", falls, 24);
    chk("t2_gap", gap_max, 4); chk("t2_tail", tail_len, 2); chk("t2_ss_len", last_ss_low, 102);

    // Overflow: 20 consecutive writes at CLK_DIV=4
    sel = 1; mon_clear();
    for (int i = 0; i < 20; i++) begin
      wr_en[1] = 1'b1; wr_data[1] = 8'(16 + i);
      step();
    end
    wr_en[1] = 1'b0;
    chk("t3_cnt", cnt[1], 16); chk("t3_full", full[1], 1); chk("t3_ovf", ovf[1], 1);
    wait_idle(1, 3000, "t3");
    chk("t3_nbytes", nbytes, 17); chk("t3_ss_falls", ss_falls, 1);
    for (int i = 0; i < 17; i++) chk($sformatf("t3_b%0d", i), bytes_q[i], 32'(16 + i));
    chk("t3_ovf_sticky", ovf[1], 1); chk("t3_full_end", full[1], 0);

    // MISO capture: 1,0,1,0,0,1,0,1 while sending 0xFF
    sel = 0; mon_clear();
    pat = 8'hA5; miso = pat[7];
    push(0, 8'hFF);
    step();
    for (int i = 0; i < 300 && busy[0]; i++) begin
      miso = (rises < 8) ? pat[3'(7 - rises)] : 1'b0;
      step();
    end
    miso = 1'b0;
    repeat (3) step();
    chk("t4_rxd", rxd[0], 8'hA5); chk("t4_last_rx", last_rx, 8'hA5);
    chk("t4_rxv_cnt", rxv_cnt, 1); chk("t4_rxv_fall", rxv_on_fall, 1);
    chk("t4_byte", bytes_q[0], 8'hFF); chk("t4_falls", falls, 8);

    // Reset mid-frame after the 4th rising edge
    mon_clear();
    wr_en[0] = 1'b1; wr_data[0] = 8'h11; step();
    wr_data[0] = 8'h22; step();
    wr_data[0] = 8'h33; step();
    wr_en[0] = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rises >= 4) begin hit = 1'b1; break; end
      step();
    end
    chk("t5_reached_rise4", 32'(hit), 1);
    rst = 1'b1;
    #1;
    chk("t5_ss", ss[0], 1); chk("t5_sclk", sclk[0], 0); chk("t5_cnt", cnt[0], 0);
    chk("t5_busy", busy[0], 0);
    step(); step();
    rst = 1'b0;
    mon_clear();
    repeat (200) step();
    chk("t5_no_rises", rises, 0); chk("t5_no_ss", ss_falls, 0); chk("t5_ss_idle", ss[0], 1);

    // CLK_DIV=1 single byte 0x81
    sel = 2; mon_clear();
    push(2, 8'h81);
    step();
    chk("t6_ss_low", ss[2], 0); chk("t6_mosi_b7", mosi[2], 1);
    wait_idle(2, 200, "t6");
    chk("t6_ss_len", last_ss_low, 17); chk("t6_byte", bytes_q[0], 8'h81);
    chk("t6_rises", rises, 8); chk("t6_gap", gap_max, 1); chk("t6_tail", tail_len, 1);
    chk("t6_ss_end", ss[2], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
